// File: rtl/dmem_responder_if.sv
// Load/store port between an RV32I core (master) and the data-memory
// responder (slave). The master holds req and the access fields stable
// until rvalid; the responder answers with a one-cycle rvalid strobe.
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, funct3, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, funct3, addr, wdata,
    output ready, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for an RV32I core: accepts one load/store at a
// time, waits WAIT_CYCLES cycles, then returns a one-cycle response.
// Byte/halfword/word stores with lane masking, sign/zero-extended loads,
// and fault reporting for illegal sizes, misalignment and out-of-range
// addresses.
// Optional build macro DMEM_TOHOST_EN: maps a word-only host mailbox
// register at 32'hFFFF_FFF0 (tohost / tohost_valid). Without it the
// mailbox outputs are tied 0 and that address is simply out of range.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  dmem_responder_if.slave    bus,
  output logic [31:0]        tohost,
  output logic               tohost_valid
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [31:0] MBOX_ADDR = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  logic [CW-1:0]   wait_cnt;

  // Captured copy of the accepted access; inputs are ignored after accept.
  logic            cap_we;
  logic [2:0]      cap_f3;
  logic [31:0]     cap_addr;
  logic [31:0]     cap_wdata;

  logic [31:0]     mem [DEPTH_WORDS];

  // Access currently being decoded: live inputs while idle (needed when
  // WAIT_CYCLES=0 and the response is formed on the accept edge),
  // otherwise the captured copy.
  logic            cur_we;
  logic [2:0]      cur_f3;
  logic [31:0]     cur_addr;
  logic [31:0]     offset;
  logic [AW-1:0]   cur_idx;
  logic            size_ok;
  logic            align_ok;
  logic            range_ok;
  logic            cur_mbox;
  logic            cur_err;
  logic [31:0]     word;
  logic [31:0]     byte_shift;
  logic [31:0]     half_shift;
  logic [31:0]     load_data;
  logic [31:0]     rdata_next;
  logic [3:0]      be;
  logic [31:0]     wd;

  // Decode the access: fault checks, load extraction and store lane masks.
  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned; a missing default would infer a latch.
  always_comb begin
    cur_we     = cap_we;
    cur_f3     = cap_f3;
    cur_addr   = cap_addr;
    if (state == IDLE) begin
      cur_we   = bus.we;
      cur_f3   = bus.funct3;
      cur_addr = bus.addr;
    end

    offset   = cur_addr - BASE_ADDR;
    cur_idx  = offset[AW+1:2];
    range_ok = (cur_addr >= BASE_ADDR) && ((offset >> 2) < 32'(DEPTH_WORDS));

`ifdef DMEM_TOHOST_EN
    cur_mbox = (cur_addr == MBOX_ADDR);
`else
    cur_mbox = 1'b0;
`endif

    if (cur_we) size_ok = cur_f3 inside {3'b000, 3'b001, 3'b010};
    else        size_ok = cur_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    case (cur_f3[1:0])
      2'b01:   align_ok = ~cur_addr[0];
      2'b10:   align_ok = (cur_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase

    cur_err = !size_ok || !align_ok ||
              (cur_mbox ? (cur_f3 != 3'b010) : !range_ok);

    word = '0;
    if (range_ok) word = mem[cur_idx];
`ifdef DMEM_TOHOST_EN
    if (cur_mbox) word = tohost;
`endif

    byte_shift = word >> {cur_addr[1:0], 3'b000};
    half_shift = word >> {cur_addr[1], 4'b0000};
    case (cur_f3)
      3'b000:  load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
      3'b001:  load_data = {{16{half_shift[15]}}, half_shift[15:0]};
      3'b100:  load_data = {24'h0, byte_shift[7:0]};
      3'b101:  load_data = {16'h0, half_shift[15:0]};
      default: load_data = word;
    endcase
    rdata_next = (cur_err || cur_we) ? 32'h0 : load_data;

    case (cap_f3[1:0])
      2'b00: begin
        be = 4'b0001 << cap_addr[1:0];
        wd = {4{cap_wdata[7:0]}};
      end
      2'b01: begin
        be = 4'b0011 << {cap_addr[1], 1'b0};
        wd = {2{cap_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = cap_wdata;
      end
    endcase
  end

  // Handshake FSM with registered ready/rvalid/rdata/err and mailbox.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      bus.ready <= 1'b1;
      bus.rvalid <= 1'b0;
      bus.rdata <= '0;
      bus.err   <= 1'b0;
      cap_we    <= 1'b0;
      cap_f3    <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
`ifdef DMEM_TOHOST_EN
      tohost       <= '0;
      tohost_valid <= 1'b0;
`endif
    end else begin
`ifdef DMEM_TOHOST_EN
      tohost_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.req) begin
            cap_we    <= bus.we;
            cap_f3    <= bus.funct3;
            cap_addr  <= bus.addr;
            cap_wdata <= bus.wdata;
            bus.ready <= 1'b0;
            wait_cnt  <= '0;
            if (WAIT_CYCLES == 0) begin
              state      <= RESP;
              bus.rvalid <= 1'b1;
              bus.rdata  <= rdata_next;
              bus.err    <= cur_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == CW'(WAIT_CYCLES - 1)) begin
            state      <= RESP;
            wait_cnt   <= '0;
            bus.rvalid <= 1'b1;
            bus.rdata  <= rdata_next;
            bus.err    <= cur_err;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          state      <= IDLE;
          bus.ready  <= 1'b1;
          bus.rvalid <= 1'b0;
          bus.rdata  <= '0;
          bus.err    <= 1'b0;
`ifdef DMEM_TOHOST_EN
          if (cap_we && !bus.err && cur_mbox) begin
            tohost       <= cap_wdata;
            tohost_valid <= 1'b1;
          end
`endif
        end
        default: begin
          state      <= IDLE;
          bus.ready  <= 1'b1;
          bus.rvalid <= 1'b0;
          bus.rdata  <= '0;
          bus.err    <= 1'b0;
        end
      endcase
    end
  end

  // Commit a fault-free store on the edge that ends the response cycle.
  // NOTE: the storage array is deliberately not reset; contents survive
  // reset, and only the reset term blocks a store interrupted by reset.
  always_ff @(posedge clk) begin
    if (!reset && state == RESP && cap_we && !bus.err && !cur_mbox) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem[cur_idx][8*l +: 8] <= wd[8*l +: 8];
      end
    end
  end

`ifndef DMEM_TOHOST_EN
  assign tohost       = '0;
  assign tohost_valid = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: one instance with
// WAIT_CYCLES=2 for the bulk of the vectors and a small WAIT_CYCLES=0
// instance for zero-wait latency. Mailbox expectations follow
// DMEM_TOHOST_EN.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_responder_if bus  ();
  dmem_responder_if bus0 ();

  logic [31:0] tohost, tohost0;
  logic        tohost_valid, tohost_valid0;

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (2),
    .BASE_ADDR   (32'h0000_0000)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .tohost       (tohost),
    .tohost_valid (tohost_valid)
  );

  dmem_responder #(
    .DEPTH_WORDS (64),
    .WAIT_CYCLES (0),
    .BASE_ADDR   (32'h0000_0000)
  ) u_dut0 (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus0.slave),
    .tohost       (tohost0),
    .tohost_valid (tohost_valid0)
  );

  int n_tests  = 0;
  int n_fail   = 0;
  int tv_count = 0;

  // Count mailbox strobes so pulse width can be checked.
  always @(negedge clk) if (tohost_valid === 1'b1) tv_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=2 instance; returns response and latency.
  task automatic access(input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    check("ready_idle", 32'(bus.ready), 32'd1);
    bus.req = 1'b1; bus.we = w; bus.funct3 = f3; bus.addr = a; bus.wdata = d;
    lat = 0; rd = '0; e = 1'b1;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("ready_busy", 32'(bus.ready), 32'd0);
      if (bus.rvalid === 1'b1) break;
    end
    check("rvalid_seen", 32'(bus.rvalid), 32'd1);
    rd = bus.rdata; e = bus.err;
    bus.req = 1'b0;
    @(negedge clk);
    check("rvalid_one_cycle", 32'(bus.rvalid), 32'd0);
    check("ready_after_resp", 32'(bus.ready), 32'd1);
  endtask

  task automatic expect_access(input string tag, input logic w, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          lat;
    access(w, f3, a, d, rd, e, lat);
    check({tag, "_lat"},   32'(lat), 32'd3);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"},   32'(e), 32'(exp_err));
  endtask

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                         F_BU = 3'b100, F_HU = 3'b101, F_BAD = 3'b011;

  initial begin
    logic seen;
    int   tv0;
    bus.req = 1'b0;  bus.we = 1'b0;  bus.funct3 = '0;  bus.addr = '0;  bus.wdata = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.funct3 = '0; bus0.addr = '0; bus0.wdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",        32'(bus.ready), 32'd1);
    check("rst_rvalid",       32'(bus.rvalid), 32'd0);
    check("rst_rdata",        bus.rdata, 32'h0);
    check("rst_err",          32'(bus.err), 32'd0);
    check("rst_tohost",       tohost, 32'h0);
    check("rst_tohost_valid", 32'(tohost_valid), 32'd0);
    check("rst_ready0",       32'(bus0.ready), 32'd1);
    reset = 1'b0;

    // Word store / load and read-after-write.
    expect_access("sw100", 1'b1, F_W, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
    expect_access("lw100", 1'b0, F_W, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte store into lane 1 and extended sub-word loads.
    expect_access("sb101",   1'b1, F_B,  32'h101, 32'h55, 32'h0, 1'b0);
    expect_access("lw100b",  1'b0, F_W,  32'h100, 32'h0, 32'hDEAD55EF, 1'b0);
    expect_access("lb103",   1'b0, F_B,  32'h103, 32'h0, 32'hFFFFFFDE, 1'b0);
    expect_access("lbu103",  1'b0, F_BU, 32'h103, 32'h0, 32'h000000DE, 1'b0);
    expect_access("lhu102",  1'b0, F_HU, 32'h102, 32'h0, 32'h0000DEAD, 1'b0);
    expect_access("lh102",   1'b0, F_H,  32'h102, 32'h0, 32'hFFFFDEAD, 1'b0);
    expect_access("lb101",   1'b0, F_B,  32'h101, 32'h0, 32'h00000055, 1'b0);

    // Halfword store, faults leave storage untouched.
    expect_access("sw200",   1'b1, F_W,   32'h200, 32'h11223344, 32'h0, 1'b0);
    expect_access("sh203",   1'b1, F_H,   32'h203, 32'hBEEF, 32'h0, 1'b1);
    expect_access("lw200a",  1'b0, F_W,   32'h200, 32'h0, 32'h11223344, 1'b0);
    expect_access("sh202",   1'b1, F_H,   32'h202, 32'hCAFEBEEF, 32'h0, 1'b0);
    expect_access("lw200b",  1'b0, F_W,   32'h200, 32'h0, 32'hBEEF3344, 1'b0);
    expect_access("sbad200", 1'b1, F_BAD, 32'h200, 32'h0, 32'h0, 1'b1);
    expect_access("lw200c",  1'b0, F_W,   32'h200, 32'h0, 32'hBEEF3344, 1'b0);
    expect_access("lw102",   1'b0, F_W,   32'h102, 32'h0, 32'h0, 1'b1);
    expect_access("lbad100", 1'b0, F_BAD, 32'h100, 32'h0, 32'h0, 1'b1);

    // Range boundary: last word is legal, one past it faults.
    expect_access("swffc",   1'b1, F_W, 32'hFFC, 32'h0F0F0F0F, 32'h0, 1'b0);
    expect_access("lwffc",   1'b0, F_W, 32'hFFC, 32'h0, 32'h0F0F0F0F, 1'b0);
    expect_access("lw1000",  1'b0, F_W, 32'h1000, 32'h0, 32'h0, 1'b1);

    // Reset during WAIT drops the pending store and its response.
    expect_access("sw300",   1'b1, F_W, 32'h300, 32'hA5A50001, 32'h0, 1'b0);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = F_W; bus.addr = 32'h300; bus.wdata = 32'h12345678;
    @(negedge clk);
    check("rst_wait_busy", 32'(bus.ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.req = 1'b0;
    check("rst_wait_ready", 32'(bus.ready), 32'd1);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rvalid !== 1'b0) seen = 1'b1;
    end
    check("rst_wait_no_rvalid", 32'(seen), 32'd0);
    expect_access("lw300", 1'b0, F_W, 32'h300, 32'h0, 32'hA5A50001, 1'b0);

    // Host mailbox.
    tv0 = tv_count;
`ifdef DMEM_TOHOST_EN
    expect_access("sw_mbox", 1'b1, F_W, 32'hFFFF_FFF0, 32'h1, 32'h0, 1'b0);
    @(negedge clk);
    check("tohost_val",   tohost, 32'h1);
    check("tohost_pulse", 32'(tv_count - tv0), 32'd1);
    expect_access("lw_mbox",  1'b0, F_W,  32'hFFFF_FFF0, 32'h0, 32'h1, 1'b0);
    expect_access("lbu_mbox", 1'b0, F_BU, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b1);
`else
    expect_access("sw_mbox", 1'b1, F_W, 32'hFFFF_FFF0, 32'h1, 32'h0, 1'b1);
    @(negedge clk);
    check("tohost_val",   tohost, 32'h0);
    check("tohost_pulse", 32'(tv_count - tv0), 32'd0);
    expect_access("lw_mbox", 1'b0, F_W, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b1);
`endif

    // Zero-wait instance: response one cycle after accept.
    @(negedge clk);
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.funct3 = F_W; bus0.addr = 32'h40; bus0.wdata = 32'hCAFEF00D;
    @(negedge clk);
    check("w0_sw_rvalid", 32'(bus0.rvalid), 32'd1);
    check("w0_sw_err",    32'(bus0.err), 32'd0);
    bus0.req = 1'b0;
    @(negedge clk);
    check("w0_sw_rvalid_off", 32'(bus0.rvalid), 32'd0);
    check("w0_sw_ready",      32'(bus0.ready), 32'd1);
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.funct3 = F_W; bus0.addr = 32'h40;
    @(negedge clk);
    check("w0_lw_rvalid", 32'(bus0.rvalid), 32'd1);
    check("w0_lw_rdata",  bus0.rdata, 32'hCAFEF00D);
    bus0.req = 1'b0;
    @(negedge clk);
    check("w0_lw_ready",  32'(bus0.ready), 32'd1);
    bus0.req = 1'b1; bus0.addr = 32'h100;
    @(negedge clk);
    check("w0_oor_rvalid", 32'(bus0.rvalid), 32'd1);
    check("w0_oor_err",    32'(bus0.err), 32'd1);
    check("w0_oor_rdata",  bus0.rdata, 32'h0);
    bus0.req = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
